imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
Parametrised, pipelined immediate generator for the decode stage. It accepts one 32-bit instruction per cycle over a valid/ready handshake. It produces the sign/zero-extended immediate at XLEN width, plus a format code, an illegal-encoding flag and a pass-through tag, after STAGES register slices. Full backpressure and a synchronous flush let it sit between fetch and issue when the core is deepened beyond three stages.

Parameters:
XLEN, 32, immediate output width; legal values 32 or 64
STAGES, 1, number of register slices; legal values 1..3
TAG_W, 5, width of opaque sideband tag (PC index / ROB id) carried alongside
ENABLE_CSR, 1, 1 = CSR opcode yields zimm; 0 = CSR opcode treated as format NONE

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
flush  in  1  synchronous kill of all in-flight entries
in_valid  in  1  instruction present
in_ready  out  1  block can accept this cycle
in_instr  in  32  raw instruction word
in_tag  in  TAG_W  sideband, returned unchanged
out_valid  out  1  result present
out_ready  in  1  consumer accepts this cycle
out_imm  out  XLEN  generated immediate
out_fmt  out  3  0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (CSR zimm), 7 reserved
out_illegal  out  1  instr[1:0] != 2'b11
out_tag  out  TAG_W  tag of the result

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-high.
- Reset state: all stage valid bits 0, so out_valid=0 and in_ready=1 on the first cycle after reset. out_imm, out_fmt, out_illegal and out_tag are all 0.
- Decode is combinational on in_instr and is captured into stage 1. Fields:
  - I, opcode 0000011 / 1100111 / 0010011, plus 0011011 only when XLEN=64: sext(instr[31:20]).
  - S, opcode 0100011: sext({instr[31:25], instr[11:7]}).
  - B, opcode 1100011: sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
  - U, opcode 0110111 / 0010111: {instr[31:12], 12'b0}, sign-extended from bit 31 to XLEN.
  - J, opcode 1101111: sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
  - Z, opcode 1110011 with ENABLE_CSR=1: zero-extended instr[19:15].
  - All other opcodes: fmt NONE, imm 0.
- sext always extends to the full XLEN.
- Illegal encodings: if instr[1:0] != 2'b11, then out_illegal=1, fmt NONE, imm 0, regardless of the remaining opcode bits.
- Pipeline: STAGES slices, each holding {valid, imm, fmt, illegal, tag}.
  - ready_k = !valid_k || ready_(k+1). The last stage uses out_ready. in_ready = ready_1.
  - A slice loads when its upstream valid and its own ready are both high. Its valid clears when downstream accepts and there is no upstream load.
  - No bubbles: throughput is 1 per cycle while out_ready=1.
  - Latency: exactly STAGES cycles from an accepted input to out_valid with out_ready held high.
- Handshake rules:
  - A transfer occurs on a cycle with valid && ready.
  - Once out_valid=1, out_imm, out_fmt, out_illegal and out_tag stay stable until accepted.
  - in_ready may depend combinationally on out_ready (ready chain). out_valid and the data outputs are registered only.
- Full/stall: with out_ready=0, the block absorbs exactly STAGES instructions, then drives in_ready=0. On out_ready returning to 1, data drains in order with no loss or duplication.
- Flush:
  - On a cycle with flush=1, every valid bit is cleared at the next edge.
  - An input presented in that same cycle is discarded, even if in_ready=1.
  - An output accepted in that same cycle counts as consumed.
  - Data registers need not clear on flush.
- Priority: rst > flush > normal operation.
- Mid-operation reset: rst asserted with entries in flight clears all of them. No partial result appears afterwards.
- Tag width: TAG_W=0 is not supported; the minimum is 1.

Test Plan:
- XLEN=32, STAGES=1, in 0xFFF00093 (addi -1) -> one cycle later out_imm=0xFFFFFFFF, fmt=1, illegal=0.
- XLEN=64, in 0x80000037 (lui) -> out_imm=0xFFFFFFFF80000000, fmt=4. In 0x0010006F (jal +2048) -> out_imm=0x800, fmt=5.
- Field decode:
  - 0xFE000EE3 (beq -4) -> out_imm=0xFFFFFFFC, fmt=3.
  - 0x3002D073 (csrrwi zimm=5) -> out_imm=5, fmt=6 with ENABLE_CSR=1; out_imm=0, fmt=0 with ENABLE_CSR=0.
  - 0x00000001 -> illegal=1, imm=0.
- STAGES=3, out_ready=0, stream tags 1..5 -> in_ready falls after 3 accepts. Release out_ready -> tags 1,2,3,4,5 emerge in order, one per cycle, none dropped.
- STAGES=2, two entries in flight, flush=1 together with in_valid=1 -> next cycle out_valid=0. Neither the in-flight entries nor the concurrent input ever appear on the output.
- rst asserted for one cycle mid-stream with out_valid=1 -> next cycle out_valid=0, in_ready=1, out_imm=0.

Source files
------------

// File: rtl/imm_gen_pipe_if.sv
// rtl/imm_gen_pipe_if.sv - instruction-in / immediate-out handshake bundle for imm_gen_pipe
interface imm_gen_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [2:0]       out_fmt;
    logic             out_illegal;
    logic [TAG_W-1:0] out_tag;

    // Block side: consumes instructions, produces immediates
    modport slave (
        input  in_valid, in_instr, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
    );

    // Environment side: feeds fetch data, sinks decode results
    modport master (
        output in_valid, in_instr, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - pipelined RISC-V immediate generator with backpressure and flush
module imm_gen_pipe #(
    parameter int XLEN       = 32,
    parameter int STAGES     = 1,
    parameter int TAG_W      = 5,
    parameter int ENABLE_CSR = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    imm_gen_pipe_if.slave bus
);
    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_Z    = 3'd6;

    logic [31:0] ins;
    logic [63:0] dec_imm64;
    logic [2:0]  dec_fmt;
    logic        dec_ill;

    assign ins = bus.in_instr;

    // Decode the immediate at 64 bits so one set of fields serves both XLEN settings
    always_comb begin
        dec_imm64 = '0;
        dec_fmt   = FMT_NONE;
        dec_ill   = 1'b0;
        if (ins[1:0] != 2'b11) begin
            dec_ill = 1'b1;
        end else begin
            case (ins[6:0])
                7'b0000011, 7'b1100111, 7'b0010011: begin
                    dec_imm64 = {{52{ins[31]}}, ins[31:20]};
                    dec_fmt   = FMT_I;
                end
                7'b0011011: begin
                    if (XLEN == 64) begin
                        dec_imm64 = {{52{ins[31]}}, ins[31:20]};
                        dec_fmt   = FMT_I;
                    end
                end
                7'b0100011: begin
                    dec_imm64 = {{52{ins[31]}}, ins[31:25], ins[11:7]};
                    dec_fmt   = FMT_S;
                end
                7'b1100011: begin
                    dec_imm64 = {{52{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
                    dec_fmt   = FMT_B;
                end
                7'b0110111, 7'b0010111: begin
                    dec_imm64 = {{32{ins[31]}}, ins[31:12], 12'b0};
                    dec_fmt   = FMT_U;
                end
                7'b1101111: begin
                    dec_imm64 = {{44{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
                    dec_fmt   = FMT_J;
                end
                7'b1110011: begin
                    if (ENABLE_CSR != 0) begin
                        dec_imm64 = {59'b0, ins[19:15]};
                        dec_fmt   = FMT_Z;
                    end
                end
                default: ;
            endcase
        end
    end

    // Slice k takes its data from src_*[k]; src_*[STAGES] is the output slice
    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] vld_d;
    logic [STAGES-1:0] load;
    logic [STAGES:0]   src_vld;
    logic [STAGES:0]   rdy;
    logic [XLEN-1:0]   imm_q [STAGES];
    logic [2:0]        fmt_q [STAGES];
    logic              ill_q [STAGES];
    logic [TAG_W-1:0]  tag_q [STAGES];
    logic [XLEN-1:0]   src_imm [STAGES+1];
    logic [2:0]        src_fmt [STAGES+1];
    logic              src_ill [STAGES+1];
    logic [TAG_W-1:0]  src_tag [STAGES+1];

    assign src_vld[0]     = bus.in_valid;
    assign src_imm[0]     = dec_imm64[XLEN-1:0];
    assign src_fmt[0]     = dec_fmt;
    assign src_ill[0]     = dec_ill;
    assign src_tag[0]     = bus.in_tag;
    assign rdy[STAGES]    = bus.out_ready;

    // A slice is ready when the consumer is ready or any slice from here downstream
    // is empty; the flattened OR avoids a combinational chain through rdy itself
    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        assign src_vld[g+1] = vld_q[g];
        assign src_imm[g+1] = imm_q[g];
        assign src_fmt[g+1] = fmt_q[g];
        assign src_ill[g+1] = ill_q[g];
        assign src_tag[g+1] = tag_q[g];
        assign rdy[g]       = bus.out_ready || !(&vld_q[STAGES-1:g]);
    end

    // Per-slice load and next-valid; flush kills everything including the incoming word
    always_comb begin
        load  = '0;
        vld_d = '0;
        for (int k = 0; k < STAGES; k++) begin
            load[k] = src_vld[k] && rdy[k];
            if (flush) begin
                vld_d[k] = 1'b0;
            end else if (load[k]) begin
                vld_d[k] = 1'b1;
            end else if (rdy[k+1]) begin
                vld_d[k] = 1'b0;
            end else begin
                vld_d[k] = vld_q[k];
            end
        end
    end

    // Slice registers; data only moves on load, so a stalled output holds steady
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                imm_q[k] <= '0;
                fmt_q[k] <= '0;
                ill_q[k] <= 1'b0;
                tag_q[k] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            for (int k = 0; k < STAGES; k++) begin
                if (load[k]) begin
                    imm_q[k] <= src_imm[k];
                    fmt_q[k] <= src_fmt[k];
                    ill_q[k] <= src_ill[k];
                    tag_q[k] <= src_tag[k];
                end
            end
        end
    end

    assign bus.in_ready    = rdy[0];
    assign bus.out_valid   = src_vld[STAGES];
    assign bus.out_imm     = src_imm[STAGES];
    assign bus.out_fmt     = src_fmt[STAGES];
    assign bus.out_illegal = src_ill[STAGES];
    assign bus.out_tag     = src_tag[STAGES];
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - self-checking bench for imm_gen_pipe across three configurations
module tb_imm_gen_pipe;
    // dut0: XLEN32 STAGES1 CSR1, dut1: XLEN64 STAGES3 CSR0, dut2: XLEN64 STAGES2 CSR1
    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_instr;
    logic [4:0]  in_tag;

    int n_checks;
    int n_fail;

    imm_gen_pipe_if #(.XLEN(32), .TAG_W(5)) bus0 ();
    imm_gen_pipe_if #(.XLEN(64), .TAG_W(5)) bus1 ();
    imm_gen_pipe_if #(.XLEN(64), .TAG_W(5)) bus2 ();

    assign bus0.in_valid = in_valid;  assign bus0.in_instr = in_instr;
    assign bus0.in_tag   = in_tag;    assign bus0.out_ready = out_ready;
    assign bus1.in_valid = in_valid;  assign bus1.in_instr = in_instr;
    assign bus1.in_tag   = in_tag;    assign bus1.out_ready = out_ready;
    assign bus2.in_valid = in_valid;  assign bus2.in_instr = in_instr;
    assign bus2.in_tag   = in_tag;    assign bus2.out_ready = out_ready;

    imm_gen_pipe #(.XLEN(32), .STAGES(1), .TAG_W(5), .ENABLE_CSR(1)) dut0 (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus0));
    imm_gen_pipe #(.XLEN(64), .STAGES(3), .TAG_W(5), .ENABLE_CSR(0)) dut1 (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus1));
    imm_gen_pipe #(.XLEN(64), .STAGES(2), .TAG_W(5), .ENABLE_CSR(1)) dut2 (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
        logic [4:0]  tag;
    } exp_t;

    // Reference decode from the ISA field rules, done with signed integer arithmetic
    function automatic exp_t ref_dec(input logic [31:0] ins, input bit is64, input bit csr,
                                     input logic [4:0] tag);
        exp_t   e;
        longint s;
        longint u;
        s = longint'(signed'(ins));
        u = longint'(ins);
        e.imm = '0; e.fmt = 3'd0; e.ill = 1'b0; e.tag = tag;
        if (ins[1:0] != 2'b11) begin
            e.ill = 1'b1;
        end else begin
            case (ins[6:0])
                7'h03, 7'h67, 7'h13: begin e.imm = 64'(s >>> 20); e.fmt = 3'd1; end
                7'h1B: if (is64) begin e.imm = 64'(s >>> 20); e.fmt = 3'd1; end
                7'h23: begin e.imm = 64'(((s >>> 25) <<< 5) | ((u >> 7) & 31)); e.fmt = 3'd2; end
                7'h63: begin
                    e.imm = 64'(((s >>> 31) <<< 12) | (((u >> 7) & 1) << 11)
                               | (((u >> 25) & 63) << 5) | (((u >> 8) & 15) << 1));
                    e.fmt = 3'd3;
                end
                7'h37, 7'h17: begin e.imm = 64'(s & ~longint'(4095)); e.fmt = 3'd4; end
                7'h6F: begin
                    e.imm = 64'(((s >>> 31) <<< 20) | (((u >> 12) & 255) << 12)
                               | (((u >> 20) & 1) << 11) | (((u >> 21) & 1023) << 1));
                    e.fmt = 3'd5;
                end
                7'h73: if (csr) begin e.imm = 64'((u >> 15) & 31); e.fmt = 3'd6; end
                default: ;
            endcase
        end
        return e;
    endfunction

    exp_t q [3][$];

    // Scoreboard: ordered queue of accepted instructions per DUT
    task automatic sb_step(input int d, input logic ov, input logic [63:0] imm,
                           input logic [2:0] fmt, input logic ill, input logic [4:0] tag,
                           input logic ir, input logic [63:0] mask);
        exp_t e;
        if (rst) begin
            q[d].delete();
            return;
        end
        if (ov && out_ready) begin
            if (q[d].size() == 0) begin
                chk($sformatf("sb%0d_unexpected_out", d), 64'(1), 64'(0));
            end else begin
                e = q[d].pop_front();
                chk($sformatf("sb%0d_imm", d), imm, e.imm & mask);
                chk($sformatf("sb%0d_fmt", d), 64'(fmt), 64'(e.fmt));
                chk($sformatf("sb%0d_ill", d), 64'(ill), 64'(e.ill));
                chk($sformatf("sb%0d_tag", d), 64'(tag), 64'(e.tag));
            end
        end
        if (flush) q[d].delete();
        else if (in_valid && ir) q[d].push_back(ref_dec(in_instr, d != 0, d != 1, in_tag));
    endtask

    always @(negedge clk) begin
        sb_step(0, bus0.out_valid, {32'b0, bus0.out_imm}, bus0.out_fmt, bus0.out_illegal,
                bus0.out_tag, bus0.in_ready, 64'hFFFF_FFFF);
        sb_step(1, bus1.out_valid, bus1.out_imm, bus1.out_fmt, bus1.out_illegal,
                bus1.out_tag, bus1.in_ready, '1);
        sb_step(2, bus2.out_valid, bus2.out_imm, bus2.out_fmt, bus2.out_illegal,
                bus2.out_tag, bus2.in_ready, '1);
    end

    typedef struct {
        logic [31:0] instr;
        logic [63:0] imm0; logic [2:0] fmt0;
        logic [63:0] imm1; logic [2:0] fmt1;
        logic [63:0] imm2; logic [2:0] fmt2;
        logic        ill;
    } vec_t;

    vec_t vecs [7];
    logic [6:0] ops [11];

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom();
        r[6:0] = ops[$urandom_range(0, 10)];
        if ($urandom_range(0, 7) == 0) r[1:0] = 2'($urandom_range(0, 2));
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc0, acc1, acc2, t;
        logic f1;
        n_checks = 0; n_fail = 0;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_instr = '0; in_tag = '0;
        ops = '{7'h03, 7'h67, 7'h13, 7'h1B, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h73, 7'h33};
        vecs[0] = '{32'hFFF00093, 64'hFFFFFFFF, 3'd1, '1, 3'd1, '1, 3'd1, 1'b0};
        vecs[1] = '{32'h80000037, 64'h80000000, 3'd4, 64'hFFFFFFFF80000000, 3'd4,
                    64'hFFFFFFFF80000000, 3'd4, 1'b0};
        vecs[2] = '{32'h0010006F, 64'h800, 3'd5, 64'h800, 3'd5, 64'h800, 3'd5, 1'b0};
        vecs[3] = '{32'hFE000EE3, 64'hFFFFFFFC, 3'd3, 64'hFFFFFFFFFFFFFFFC, 3'd3,
                    64'hFFFFFFFFFFFFFFFC, 3'd3, 1'b0};
        vecs[4] = '{32'h3002D073, 64'h5, 3'd6, 64'h0, 3'd0, 64'h5, 3'd6, 1'b0};
        vecs[5] = '{32'h00000001, 64'h0, 3'd0, 64'h0, 3'd0, 64'h0, 3'd0, 1'b1};
        vecs[6] = '{32'hFFF0009B, 64'h0, 3'd0, '1, 3'd1, '1, 3'd1, 1'b0};

        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ov0", 64'(bus0.out_valid), 0); chk("rst_ir0", 64'(bus0.in_ready), 1);
        chk("rst_ov1", 64'(bus1.out_valid), 0); chk("rst_ir1", 64'(bus1.in_ready), 1);
        chk("rst_ov2", 64'(bus2.out_valid), 0); chk("rst_ir2", 64'(bus2.in_ready), 1);
        chk("rst_imm1", bus1.out_imm, 0);       chk("rst_fmt1", 64'(bus1.out_fmt), 0);
        chk("rst_ill2", 64'(bus2.out_illegal), 0); chk("rst_tag0", 64'(bus0.out_tag), 0);

        // Directed vectors: latency of exactly STAGES and hand-computed immediates
        for (int i = 0; i < 7; i++) begin
            step();
            in_valid = 1'b1; in_instr = vecs[i].instr; in_tag = 5'(i + 1);
            step();
            in_valid = 1'b0;
            for (int k = 1; k <= 3; k++) begin
                @(negedge clk);
                chk($sformatf("lat0_v%0d_k%0d", i, k), 64'(bus0.out_valid), 64'(k == 1));
                chk($sformatf("lat1_v%0d_k%0d", i, k), 64'(bus1.out_valid), 64'(k == 3));
                chk($sformatf("lat2_v%0d_k%0d", i, k), 64'(bus2.out_valid), 64'(k == 2));
                if (k == 1) begin
                    chk($sformatf("v%0d_imm0", i), 64'(bus0.out_imm), vecs[i].imm0);
                    chk($sformatf("v%0d_fmt0", i), 64'(bus0.out_fmt), 64'(vecs[i].fmt0));
                    chk($sformatf("v%0d_ill0", i), 64'(bus0.out_illegal), 64'(vecs[i].ill));
                end
                if (k == 2) begin
                    chk($sformatf("v%0d_imm2", i), bus2.out_imm, vecs[i].imm2);
                    chk($sformatf("v%0d_fmt2", i), 64'(bus2.out_fmt), 64'(vecs[i].fmt2));
                end
                if (k == 3) begin
                    chk($sformatf("v%0d_imm1", i), bus1.out_imm, vecs[i].imm1);
                    chk($sformatf("v%0d_fmt1", i), 64'(bus1.out_fmt), 64'(vecs[i].fmt1));
                    chk($sformatf("v%0d_tag1", i), 64'(bus1.out_tag), 64'(i + 1));
                end
                step();
            end
        end

        // Stall: each DUT absorbs exactly STAGES entries, then drains in order
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00100093;
        t = 1; in_tag = 5'(t); acc0 = 0; acc1 = 0; acc2 = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus0.in_ready) acc0++;
            if (bus1.in_ready) acc1++;
            if (bus2.in_ready) acc2++;
            f1 = bus1.in_ready;
            step();
            if (f1) begin t++; in_tag = 5'(t); end
        end
        chk("stall_acc0", 64'(acc0), 1); chk("stall_acc1", 64'(acc1), 3);
        chk("stall_acc2", 64'(acc2), 2);
        chk("stall_ir0", 64'(bus0.in_ready), 0); chk("stall_ir1", 64'(bus1.in_ready), 0);
        chk("stall_ir2", 64'(bus2.in_ready), 0);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("drain_ov_%0d", i), 64'(bus1.out_valid), 1);
            chk($sformatf("drain_tag_%0d", i), 64'(bus1.out_tag), 64'(i + 1));
            f1 = in_valid && bus1.in_ready;
            step();
            if (f1) begin
                t++;
                if (t > 5) in_valid = 1'b0;
                else in_tag = 5'(t);
            end
        end
        in_valid = 1'b0;
        repeat (4) step();

        // Flush with two entries in flight plus a concurrent input
        out_ready = 1'b0; in_valid = 1'b1; in_tag = 5'd10;
        step();
        in_tag = 5'd11;
        step();
        flush = 1'b1; in_tag = 5'd12;
        @(negedge clk);
        chk("flush_pre_ov2", 64'(bus2.out_valid), 1);
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("flush_ov0_%0d", c), 64'(bus0.out_valid), 0);
            chk($sformatf("flush_ov1_%0d", c), 64'(bus1.out_valid), 0);
            chk($sformatf("flush_ov2_%0d", c), 64'(bus2.out_valid), 0);
            step();
        end

        // Mid-stream reset with results held at the output
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'hFFF00093; in_tag = 5'd7;
        step();
        step();
        @(negedge clk);
        chk("mrst_pre_ov0", 64'(bus0.out_valid), 1);
        rst = 1'b1; in_valid = 1'b0;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_ov0", 64'(bus0.out_valid), 0); chk("mrst_ir0", 64'(bus0.in_ready), 1);
        chk("mrst_imm0", 64'(bus0.out_imm), 0);  chk("mrst_ov2", 64'(bus2.out_valid), 0);
        chk("mrst_ir1", 64'(bus1.in_ready), 1);  chk("mrst_imm2", bus2.out_imm, 0);
        step();

        // Randomised traffic against the scoreboard
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_instr  = rand_instr();
            in_tag    = 5'($urandom());
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            rst       = ($urandom_range(0, 299) == 0);
            step();
        end
        in_valid = 1'b0; flush = 1'b0; rst = 1'b0; out_ready = 1'b1;
        repeat (8) step();
        @(negedge clk);
        chk("end_q0", 64'(q[0].size()), 0); chk("end_q1", 64'(q[1].size()), 0);
        chk("end_q2", 64'(q[2].size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
